// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM states, grant owner, memory access sizes
// and the conflict-resolution helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // Same encoding readDataExtend uses for memSize.
  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic gnt_i;
    logic gnt_d;
  } grant_t;

  // On conflict data wins unless it also won last time, so fetch cannot starve.
  function automatic grant_t arb_pick(input logic   if_elig,
                                      input logic   d_elig,
                                      input grant_e last_grant);
    grant_t g;
    g.gnt_i = if_elig & (~d_elig | (last_grant == GNT_D));
    g.gnt_d = d_elig  & (~if_elig | (last_grant == GNT_I));
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// mem_timeout_ctr: per-transaction wait counter with a sticky timeout error flag.
// Only instantiated when MEMARB_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_x,
  input  logic i_clr,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_timeout,
  output logic o_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Fires in the TIMEOUT_CYCLES-th busy cycle that sees no ack.
  assign o_timeout = i_busy & ~i_ack & (cnt_q == CNT_LAST);
  assign o_err     = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | o_timeout;
    if (i_clr | o_timeout) begin
      cnt_d = '0;
    end else if (i_busy & ~i_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Define MEMARB_TIMEOUT_EN to add the ack timeout counter and sticky o_err.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  output logic              o_if_stall,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [1:0]        i_d_size,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_ready,
  output logic              o_d_stall,
  output logic              o_m_req,
  output logic              o_m_we,
  output logic [1:0]        o_m_size,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic              i_m_ack,
  output logic              o_err
);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [1:0]        m_size_q, m_size_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

  logic              busy;
  logic              ack;
  logic              timeout;
  logic              done;
  logic              can_arb;
  logic              if_elig;
  logic              d_elig;
  logic              if_hit;
  grant_t            gnt;
  logic [DATA_W-1:0] rdata;

  assign busy = (state_q != IDLE);
  assign ack  = busy & i_m_ack;
  assign done = ack | timeout;

  // A redirected PC no longer matches the latched address: complete silently.
  assign if_hit     = i_if_req & (i_if_addr == m_addr_q);
  assign o_if_ready = (state_q == BUSY_I) & done & if_hit;
  assign o_d_ready  = (state_q == BUSY_D) & done & i_d_req;
  assign o_if_stall = i_if_req & ~o_if_ready;
  assign o_d_stall  = i_d_req & ~o_d_ready;

  assign rdata      = timeout ? '0 : i_m_rdata;
  assign o_if_rdata = rdata;
  assign o_d_rdata  = rdata;

  assign o_m_req   = m_req_q;
  assign o_m_we    = m_we_q;
  assign o_m_size  = m_size_q;
  assign o_m_addr  = m_addr_q;
  assign o_m_wdata = m_wdata_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_size_d     = m_size_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;

    // The completing owner sits out its ack cycle; the other side may chain in.
    can_arb = (state_q == IDLE) | ack;
    if_elig = i_if_req & can_arb & (state_q != BUSY_I);
    d_elig  = i_d_req  & can_arb & (state_q != BUSY_D);
    gnt     = arb_pick(if_elig, d_elig, last_grant_q);

    if (gnt.gnt_i) begin
      state_d      = BUSY_I;
      last_grant_d = GNT_I;
      m_req_d      = 1'b1;
      m_we_d       = 1'b0;
      m_size_d     = MEM_SIZE_WORD;
      m_addr_d     = i_if_addr;
      m_wdata_d    = '0;
    end else if (gnt.gnt_d) begin
      state_d      = BUSY_D;
      last_grant_d = GNT_D;
      m_req_d      = 1'b1;
      m_we_d       = i_d_we;
      m_size_d     = i_d_size;
      m_addr_d     = i_d_addr;
      m_wdata_d    = i_d_wdata;
    end else if (done) begin
      state_d = IDLE;
      m_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_D;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_size_q     <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_size_q     <= m_size_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset_x  (reset_x),
    .i_clr    (gnt.gnt_i | gnt.gnt_d),
    .i_busy   (busy),
    .i_ack    (ack),
    .o_timeout(timeout),
    .o_err    (o_err)
  );
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a delayed-ack memory model plus directed
// fetch/data scenarios; expected read data is queued at issue and checked on ready.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_x;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic [DW-1:0] o_if_rdata;
  logic          o_if_ready;
  logic          o_if_stall;
  logic          i_d_req;
  logic          i_d_we;
  logic [1:0]    i_d_size;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata;
  logic [DW-1:0] o_d_rdata;
  logic          o_d_ready;
  logic          o_d_stall;
  logic          o_m_req;
  logic          o_m_we;
  logic [1:0]    o_m_size;
  logic [AW-1:0] o_m_addr;
  logic [DW-1:0] o_m_wdata;
  logic [DW-1:0] i_m_rdata;
  logic          i_m_ack;
  logic          o_err;

  logic model_ack = 1'b0;
  logic man_ack   = 1'b0;
  assign i_m_ack = model_ack | man_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset_x   (reset_x),
    .i_if_req  (i_if_req),
    .i_if_addr (i_if_addr),
    .o_if_rdata(o_if_rdata),
    .o_if_ready(o_if_ready),
    .o_if_stall(o_if_stall),
    .i_d_req   (i_d_req),
    .i_d_we    (i_d_we),
    .i_d_size  (i_d_size),
    .i_d_addr  (i_d_addr),
    .i_d_wdata (i_d_wdata),
    .o_d_rdata (o_d_rdata),
    .o_d_ready (o_d_ready),
    .o_d_stall (o_d_stall),
    .o_m_req   (o_m_req),
    .o_m_we    (o_m_we),
    .o_m_size  (o_m_size),
    .o_m_addr  (o_m_addr),
    .o_m_wdata (o_m_wdata),
    .i_m_rdata (i_m_rdata),
    .i_m_ack   (i_m_ack),
    .o_err     (o_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [31:0] data;
    bit          has_data;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];

  // Memory model: acks ack_delay cycles after a transaction appears on the bus.
  bit          mem_en    = 1'b0;
  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;

  always @(posedge clk) begin
    #1;
    model_ack = 1'b0;
    i_m_rdata = 32'hDEAD_BEEF;
    if (mem_en && o_m_req) begin
      if (wait_cnt == ack_delay) begin
        model_ack = 1'b1;
        i_m_rdata = mem_data(o_m_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (o_if_ready) begin
      chk("if_ready_expected", 32'(if_q.size() > 0), 1);
      if (if_q.size() > 0) begin
        e = if_q.pop_front();
        if (e.has_data) chk("if_rdata", o_if_rdata, e.data);
      end
    end
    if (o_d_ready) begin
      chk("d_ready_expected", 32'(d_q.size() > 0), 1);
      if (d_q.size() > 0) begin
        e = d_q.pop_front();
        if (e.has_data) chk("d_rdata", o_d_rdata, e.data);
      end
    end
  end

  logic        lg_req[8];
  logic        lg_we[8];
  logic [1:0]  lg_size[8];
  logic [31:0] lg_addr[8];
  logic [31:0] lg_wdata[8];
  logic        lg_ifr[8];
  logic        lg_dr[8];
  logic        lg_ifs[8];
  logic        lg_err[8];

  // Logs n cycles; each requester drops its req after its n-th ready.
  task automatic run(input int unsigned n, input int unsigned if_n, input int unsigned d_n);
    int unsigned if_cnt = 0;
    int unsigned d_cnt  = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      lg_req[i]   = o_m_req;
      lg_we[i]    = o_m_we;
      lg_size[i]  = o_m_size;
      lg_addr[i]  = o_m_addr;
      lg_wdata[i] = o_m_wdata;
      lg_ifr[i]   = o_if_ready;
      lg_dr[i]    = o_d_ready;
      lg_ifs[i]   = o_if_stall;
      lg_err[i]   = o_err;
      if (o_if_ready) if_cnt++;
      if (o_d_ready)  d_cnt++;
      @(posedge clk);
      #1;
      if (if_cnt >= if_n) i_if_req = 1'b0;
      if (d_cnt >= d_n)   i_d_req  = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_x = 1'b1;
  endtask

  initial begin
    int stalls;
    int readies;
    reset_x   = 1'b0;
    i_if_req  = 1'b0;
    i_if_addr = '0;
    i_d_req   = 1'b0;
    i_d_we    = 1'b0;
    i_d_size  = 2'b10;
    i_d_addr  = '0;
    i_d_wdata = '0;
    do_reset();

    @(negedge clk);
    chk("rst_m_req", 32'(o_m_req), 0);
    chk("rst_m_addr", o_m_addr, 0);
    chk("rst_m_we", 32'(o_m_we), 0);
    chk("rst_err", 32'(o_err), 0);
    @(posedge clk);
    #1;

    // Fetch only, memory acks two cycles after o_m_req.
    mem_en    = 1'b1;
    ack_delay = 2;
    i_if_req  = 1'b1;
    i_if_addr = 32'h0001_0000;
    if_q.push_back('{mem_data(32'h0001_0000), 1'b1});
    run(6, 1, 1);
    stalls  = 0;
    readies = 0;
    for (int i = 0; i < 6; i++) begin
      stalls  += int'(lg_ifs[i]);
      readies += int'(lg_ifr[i]);
    end
    chk("f1_req_lat", 32'(lg_req[0]), 0);
    chk("f1_addr", lg_addr[1], 32'h0001_0000);
    chk("f1_size", 32'(lg_size[1]), 2);
    chk("f1_stalls", 32'(stalls), 3);
    chk("f1_readies", 32'(readies), 1);
    chk("f1_ready_cyc", 32'(lg_ifr[3]), 1);
    chk("f1_idle_after", 32'(lg_req[4]), 0);

    // Conflict straight after reset: fetch first, data chained without bubble.
    do_reset();
    ack_delay = 1;
    i_if_req  = 1'b1;
    i_if_addr = 32'h0001_0004;
    i_d_req   = 1'b1;
    i_d_we    = 1'b0;
    i_d_size  = 2'b10;
    i_d_addr  = 32'h0000_2000;
    if_q.push_back('{mem_data(32'h0001_0004), 1'b1});
    d_q.push_back('{mem_data(32'h0000_2000), 1'b1});
    run(6, 1, 1);
    chk("c1_first_addr", lg_addr[1], 32'h0001_0004);
    chk("c1_if_ready", 32'(lg_ifr[2]), 1);
    chk("c1_no_bubble", 32'(lg_req[3]), 1);
    chk("c1_second_addr", lg_addr[3], 32'h0000_2000);
    chk("c1_d_ready", 32'(lg_dr[4]), 1);
    chk("c1_idle_after", 32'(lg_req[5]), 0);

    // Persistent conflict: grants alternate I, D, I, D.
    ack_delay = 0;
    i_if_req  = 1'b1;
    i_d_req   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_q.push_back('{mem_data(32'h0001_0004), 1'b1});
      d_q.push_back('{mem_data(32'h0000_2000), 1'b1});
    end
    run(6, 2, 2);
    chk("alt_g1", lg_addr[1], 32'h0001_0004);
    chk("alt_g2", lg_addr[2], 32'h0000_2000);
    chk("alt_g3", lg_addr[3], 32'h0001_0004);
    chk("alt_g4", lg_addr[4], 32'h0000_2000);
    chk("alt_busy", 32'({lg_req[1], lg_req[2], lg_req[3], lg_req[4]}), 32'hF);
    chk("alt_idle_after", 32'(lg_req[5]), 0);

    // PC redirect while a fetch is in flight.
    ack_delay = 2;
    i_if_req  = 1'b1;
    i_if_addr = 32'h0001_0008;
    if_q.push_back('{mem_data(32'h0001_0100), 1'b1});
    run(2, 1, 1);
    chk("redir_first_addr", lg_addr[1], 32'h0001_0008);
    i_if_addr = 32'h0001_0100;
    run(6, 1, 1);
    chk("redir_no_ready", 32'(lg_ifr[1]), 0);
    chk("redir_idle", 32'(lg_req[2]), 0);
    chk("redir_regrant", lg_addr[3], 32'h0001_0100);
    chk("redir_ready", 32'(lg_ifr[5]), 1);

    // Store: bus fields registered exactly and held despite input changes.
    ack_delay = 3;
    i_d_req   = 1'b1;
    i_d_we    = 1'b1;
    i_d_size  = 2'b00;
    i_d_addr  = 32'h0000_3001;
    i_d_wdata = 32'h0000_00AB;
    d_q.push_back('{32'h0, 1'b0});
    run(2, 1, 1);
    chk("st_we", 32'(lg_we[1]), 1);
    chk("st_size", 32'(lg_size[1]), 0);
    chk("st_addr", lg_addr[1], 32'h0000_3001);
    chk("st_wdata", lg_wdata[1], 32'h0000_00AB);
    i_d_we    = 1'b0;
    i_d_size  = 2'b10;
    i_d_addr  = 32'hDEAD_0000;
    i_d_wdata = 32'h0000_0055;
    run(5, 1, 1);
    chk("st_hold_addr", lg_addr[1], 32'h0000_3001);
    chk("st_hold_wdata", lg_wdata[1], 32'h0000_00AB);
    chk("st_hold_we", 32'(lg_we[1]), 1);
    chk("st_ready", 32'(lg_dr[2]), 1);
    chk("st_idle_after", 32'(lg_req[3]), 0);

    // Reset mid-transaction; an ack arriving afterwards is ignored.
    mem_en   = 1'b0;
    i_d_req  = 1'b1;
    i_d_addr = 32'h0000_4000;
    run(2, 1, 1);
    chk("rm_busy", 32'(lg_req[1]), 1);
    reset_x = 1'b0;
    man_ack = 1'b1;
    #1;
    chk("rm_req_cleared", 32'(o_m_req), 0);
    chk("rm_addr_cleared", o_m_addr, 0);
    @(negedge clk);
    reset_x   = 1'b1;
    mem_en    = 1'b1;
    ack_delay = 0;
    #1;
    chk("rm_ack_ignored", 32'(o_d_ready), 0);
    chk("rm_stall", 32'(o_d_stall), 1);
    d_q.push_back('{mem_data(32'h0000_4000), 1'b1});
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    run(3, 1, 1);
    chk("rm_regrant_addr", lg_addr[0], 32'h0000_4000);
    chk("rm_ready", 32'(lg_dr[0]), 1);

`ifdef MEMARB_TIMEOUT_EN
    // No ack: timeout after four busy cycles, zero data, sticky error.
    mem_en   = 1'b0;
    i_d_req  = 1'b1;
    i_d_we   = 1'b0;
    i_d_addr = 32'h0000_5000;
    d_q.push_back('{32'h0, 1'b1});
    run(7, 1, 1);
    chk("to_busy4", 32'(lg_req[4]), 1);
    chk("to_ready", 32'(lg_dr[4]), 1);
    chk("to_no_early", 32'(lg_dr[3]), 0);
    chk("to_err_before", 32'(lg_err[3]), 0);
    chk("to_req_drop", 32'(lg_req[5]), 0);
    chk("to_err_set", 32'(lg_err[5]), 1);
    chk("to_err_sticky", 32'(lg_err[6]), 1);
`else
    chk("err_tied_low", 32'(o_err), 0);
`endif

    chk("if_q_drained", 32'(if_q.size()), 0);
    chk("d_q_drained", 32'(d_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
